// File: rtl/nios2_key_pio.sv
// nios2_key_pio: Avalon-MM input PIO for push-buttons and switches.
// Synchronizes, debounces, edge-captures and raises a masked level IRQ.
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-high reset
//   address     register select (0 data, 1 direction, 2 irq_mask, 3 edge_capture)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   in_port     asynchronous external inputs
//   readdata    registered read data, read latency 1
//   irq         level interrupt, active high
module nios2_key_pio #(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter int               EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] INPUT_RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev_stable;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_mux;
    logic             wr;
    logic             unused_wdata;

    // Upper writedata bits are meaningless for narrow ports.
    assign unused_wdata = ^writedata;

    assign wr = chipselect & ~write_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= INPUT_RESET_VAL;
            sync2 <= INPUT_RESET_VAL;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stable <= INPUT_RESET_VAL;
                end else begin
                    stable <= sync2;
                end
            end
        end else begin : g_filter
            localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
            localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt [WIDTH];

            // A bit accepts a new level only after it has differed from
            // the accepted level for DEBOUNCE_CYCLES cycles in a row.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stable <= INPUT_RESET_VAL;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (sync2[i] == stable[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == CNT_MAX) begin
                            stable[i] <= sync2[i];
                            cnt[i]    <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end
                end
            end
        end
    endgenerate

    assign rise = stable & ~prev_stable;
    assign fall = ~stable & prev_stable;

    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_det = rise;
        end else if (EDGE_TYPE == 1) begin
            edge_det = fall;
        end else begin
            edge_det = rise | fall;
        end
    end

    assign clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        unique case (address)
            2'd0: rd_mux = 32'(stable);
            2'd1: rd_mux = '0;
            2'd2: rd_mux = 32'(irq_mask);
            2'd3: rd_mux = 32'(edge_capture);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_stable  <= INPUT_RESET_VAL;
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
        end else begin
            prev_stable <= stable;
            // A fresh edge wins over a clear of the same bit.
            edge_capture <= (edge_capture & ~clr) | edge_det;
            if (wr && address == 2'd2) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            readdata <= rd_mux;
        end
    end

    // Built from registers only, so the level is glitch-free.
    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios2_key_pio.sv
// tb_nios2_key_pio: directed and random checks of nios2_key_pio.
// Two instances: filtered/falling and bypassed/any-edge.
module tb_nios2_key_pio;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [3:0]  in_a = 4'hF;
    logic [3:0]  in_b = 4'hF;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        irq_a;
    logic        irq_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    nios2_key_pio #(
        .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)
    ) dut_a (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_a),
        .readdata(rd_a), .irq(irq_a)
    );

    nios2_key_pio #(
        .WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)
    ) dut_b (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_b),
        .readdata(rd_b), .irq(irq_b)
    );

    // Reference model: keeps the full history of sampled inputs and
    // decides acceptance by looking back over a window of samples.
    int          ndeb [2] = '{4, 0};
    int          etype [2] = '{1, 2};
    logic [3:0]  hist [2][8192];
    logic [3:0]  m_st [2];
    logic [3:0]  m_pv [2];
    logic [3:0]  m_ec [2];
    logic [3:0]  m_mk [2];
    logic [31:0] m_rd [2];
    int          lf [2][4];
    int          t = 0;
    int          rst_left = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic [3:0] inp, ost, nst, e, clr, rise, fall;
        logic       wr;
        bit         all;
        wr  = chipselect && !write_n;
        clr = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
        for (int d = 0; d < 2; d++) begin
            inp = (d == 0) ? in_a : in_b;
            if (reset) begin
                hist[d][t] = 4'hF;
                m_st[d] = 4'hF;
                m_pv[d] = 4'hF;
                m_ec[d] = 4'h0;
                m_mk[d] = 4'h0;
                m_rd[d] = 32'h0;
                for (int b = 0; b < 4; b++) lf[d][b] = -100;
            end else begin
                hist[d][t] = inp;
                ost = m_st[d];
                nst = ost;
                if (ndeb[d] == 0) begin
                    if (t >= 2) nst = hist[d][t-2];
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (t - 1 - ndeb[d] >= 0 && t >= lf[d][b] + ndeb[d]) begin
                            all = 1;
                            for (int k = t - 1 - ndeb[d]; k <= t - 2; k++)
                                if (hist[d][k][b] == ost[b]) all = 0;
                            if (all) begin
                                nst[b] = ~ost[b];
                                lf[d][b] = t;
                            end
                        end
                    end
                end
                rise = ost & ~m_pv[d];
                fall = ~ost & m_pv[d];
                e = (etype[d] == 0) ? rise :
                    (etype[d] == 1) ? fall : (rise | fall);
                case (address)
                    2'd0: m_rd[d] = {28'h0, ost};
                    2'd1: m_rd[d] = 32'h0;
                    2'd2: m_rd[d] = {28'h0, m_mk[d]};
                    default: m_rd[d] = {28'h0, m_ec[d]};
                endcase
                m_ec[d] = (m_ec[d] & ~clr) | e;
                if (wr && address == 2'd2) m_mk[d] = writedata[3:0];
                m_pv[d] = ost;
                m_st[d] = nst;
            end
        end
        t++;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("rd_a", rd_a, m_rd[0]);
        chk("irq_a", {31'b0, irq_a}, {31'b0, |(m_ec[0] & m_mk[0])});
        chk("rd_b", rd_b, m_rd[1]);
        chk("irq_b", {31'b0, irq_b}, {31'b0, |(m_ec[1] & m_mk[1])});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int b = 0; b < 4; b++) lf[d][b] = -100;

        // Reset state
        ticks(3);
        chk("rst_rd_a", rd_a, 32'h0);
        chk("rst_irq_a", {31'b0, irq_a}, 32'h0);
        chk("rst_rd_b", rd_b, 32'h0);
        reset = 1'b0;
        ticks(4);
        address = 2'd0;
        tick();
        chk("idle_data", rd_a, 32'hF);
        wr_reg(2'd2, 32'hF);

        // Filtered press
        address = 2'd0;
        in_a = 4'hE;
        ticks(6);
        chk("press_irq_early", {31'b0, irq_a}, 32'h0);
        tick();
        chk("press_irq", {31'b0, irq_a}, 32'h1);
        chk("press_data", rd_a, 32'hE);
        address = 2'd3;
        tick();
        chk("press_ecap", rd_a, 32'h1);

        // Glitch rejection
        wr_reg(2'd3, 32'hF);
        address = 2'd0;
        in_a = 4'hC;
        ticks(3);
        in_a = 4'hE;
        ticks(8);
        chk("glitch_data", rd_a, 32'hE);
        chk("glitch_irq", {31'b0, irq_a}, 32'h0);

        // Clear/set collision
        in_a = 4'hF;
        ticks(8);
        in_a = 4'hE;
        ticks(6);
        wr_reg(2'd3, 32'h1);
        chk("coll_irq", {31'b0, irq_a}, 32'h1);
        tick();
        chk("coll_ecap", rd_a, 32'h1);
        wr_reg(2'd3, 32'h1);
        chk("clr_irq", {31'b0, irq_a}, 32'h0);
        tick();
        chk("clr_ecap", rd_a, 32'h0);

        // Masking
        in_a = 4'hA;
        ticks(8);
        chk("mask_ecap", rd_a, 32'h4);
        wr_reg(2'd2, 32'hB);
        chk("masked_irq", {31'b0, irq_a}, 32'h0);
        address = 2'd3;
        tick();
        chk("masked_ecap", rd_a, 32'h4);
        wr_reg(2'd2, 32'hF);
        chk("unmask_irq", {31'b0, irq_a}, 32'h1);
        wr_reg(2'd3, 32'hF);
        in_a = 4'hF;
        ticks(8);

        // Any-edge, no filter
        address = 2'd3;
        in_b = 4'h7;
        ticks(10);
        chk("any_fall_ecap", rd_b, 32'h8);
        chk("any_fall_irq", {31'b0, irq_b}, 32'h1);
        wr_reg(2'd3, 32'h8);
        address = 2'd1;
        tick();
        in_b = 4'hF;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("dir_read", rd_b, 32'h0);
        end
        address = 2'd3;
        tick();
        chk("any_rise_ecap", rd_b, 32'h8);
        wr_reg(2'd3, 32'h8);

        // Reset mid-debounce with irq pending
        in_a = 4'h7;
        ticks(8);
        in_a = 4'h6;
        ticks(4);
        chk("pre_rst_irq", {31'b0, irq_a}, 32'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_irq", {31'b0, irq_a}, 32'h0);
        chk("async_rst_rd", rd_a, 32'h0);
        in_a = 4'hF;
        ticks(3);
        reset = 1'b0;
        ticks(10);
        address = 2'd3;
        tick();
        chk("post_rst_ecap", rd_a, 32'h0);
        address = 2'd2;
        tick();
        chk("post_rst_mask", rd_a, 32'h0);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) in_a[$urandom_range(3)] ^= 1'b1;
            if ($urandom_range(3) == 0) in_b[$urandom_range(3)] ^= 1'b1;
            address = 2'($urandom_range(3));
            if ($urandom_range(5) == 0) begin
                chipselect = 1'b1;
                write_n = 1'b0;
                writedata = $urandom();
            end else begin
                chipselect = 1'($urandom_range(1));
                write_n = 1'b1;
            end
            if (rst_left > 0) begin
                rst_left--;
                reset = 1'b1;
            end else if ($urandom_range(399) == 0) begin
                rst_left = 3;
                reset = 1'b1;
            end else begin
                reset = 1'b0;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
